fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch (IF) stage of pipelined_risc_v_cpu; directly upstream of decode.
//  Holds the PC and issues one word fetch at a time to a multi-cycle instruction memory.
//  Buffers each returned word in a 2-entry queue whose head is the IF/ID register.
//  Applies redirects (taken branch/jump from EX) by retargeting the PC and flushing wrong-path words.
// PARAMETERS
//  WIDTH     32      PC / address width (XLEN)
//  RESET_PC  32'h0   PC of the first fetch after reset
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      asynchronous reset, active-high
//  imem_req_valid  out  1      fetch request valid
//  imem_req_addr   out  WIDTH  fetch address (bits [1:0] always 0)
//  imem_req_ready  in   1      memory accepts request this cycle
//  imem_rsp_valid  in   1      read data valid (one pulse per accepted request)
//  imem_rsp_data   in   32     instruction word
//  redirect_valid  in   1      one-cycle redirect request from EX
//  redirect_pc     in   WIDTH  redirect target
//  id_valid        out  1      IF/ID register holds a valid instruction
//  id_pc           out  WIDTH  PC of id_instr
//  id_instr        out  32     instruction to decode
//  id_ready        in   1      decode consumes id_* this cycle (if id_valid)
// BEHAVIOUR
//  Reset (async, rst=1):
//   - pc=RESET_PC, queue empty, no request outstanding, drop flag clear, FSM=REQ.
//   - id_valid=0, id_pc=0, id_instr=32'h0000_0013 (NOP).
//   - imem_req_valid=0 while rst is high.
//  FSM {REQ, WAIT}:
//   - REQ:  imem_req_valid=1 iff queue occupancy<2; addr=pc.
//           On valid&&ready: latch inflight_pc=pc, pc<=pc+4 (mod 2^WIDTH), go WAIT.
//   - WAIT: imem_req_valid=0. On imem_rsp_valid go REQ.
//           If drop=0, push {inflight_pc, data}; if drop=1, discard the word and clear drop.
//   - imem_rsp_valid in REQ (nothing outstanding) is ignored, including a stale
//     response arriving after reset.
//  Queue (2 entries):
//   - Head drives id_*; id_valid=(occupancy!=0).
//   - Pop when id_valid&&id_ready; push and pop in the same cycle are legal.
//   - Occupancy never exceeds 2: a request is issued only while occupancy<2, and at
//     most one request is outstanding.
//   - When empty, id_instr=NOP and id_pc holds its last value.
//  Redirect (highest priority, same-cycle events):
//   - pc<=redirect_pc with [1:0] forced to 0; queue cleared, so id_valid=0 next cycle.
//   - A concurrent id_ready pop is irrelevant.
//   - If FSM=WAIT, or a request is accepted in the redirect cycle: set drop=1 and
//     the FSM goes/stays WAIT.
//   - If WAIT and imem_rsp_valid in the redirect cycle: discard the word, drop=0,
//     go REQ.
//   - A request issued in the redirect cycle still uses the old pc.
//   - Back-to-back redirects: the last one wins; only one drop is ever pending.
//  Latency and throughput:
//   - Zero-wait memory (ready=1, rsp next cycle): request at cycle t, rsp at t+1,
//     id_valid at t+2.
//   - Peak rate is 1 instruction per 2 cycles.
//   - First request is issued in the first cycle after rst falls.
// STRUCTURE
//  riscv_pkg (shared):
//   - XLEN=32, ILEN=32, NOP_INSTR=32'h0000_0013.
//   - fetch_state_t enum {FS_REQ, FS_WAIT}.
//   - if_id_t struct {pc, instr}, reused by the decode stage.
//  Sub-module fetch_queue:
//   - 2-entry FIFO of if_id_t with a synchronous flush input.
//   - Outputs head/occupancy; read-head first-word-fall-through.
//  The fetch_stage top holds the PC, FSM, drop flag and inflight_pc.
// TESTING
//  T1 reset: rst=1 mid-WAIT -> id_valid=0, id_instr=0x00000013, req_valid=0;
//     after release first addr=0x0.
//  T2 zero-wait stream, id_ready=1, mem returns addr^0xA5A50000:
//     id_pc 0,4,8 on cycles 2,4,6, instr matching.
//  T3 backpressure: id_ready=0 -> exactly 2 words queued (pc 0,4); req_valid stays 0;
//     release -> pc 0,4,8 in order, none lost or duplicated.
//  T4 redirect while WAIT (rsp delayed 3 cycles), redirect_pc=0x103:
//     stale word dropped; next addr=0x100; id_pc=0x100 first valid.
//  T5 redirect in same cycle as imem_rsp_valid and id_ready:
//     word discarded, queue empty next cycle, next addr=redirect target.
//  T6 wrap: RESET_PC=0xFFFFFFFC -> addrs 0xFFFFFFFC then 0x00000000.
//     Also check that a spurious imem_rsp_valid in REQ is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: XLEN/ILEN, NOP encoding, fetch FSM states and the
// IF/ID payload that the decode stage also consumes.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FS_REQ  = 1'b0,
    FS_WAIT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry first-word-fall-through FIFO of IF/ID payloads; entry 0 is always the head.
// A synchronous flush empties it and overrides any push or pop in the same cycle.
module fetch_queue
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic       i_push,
  input  if_id_t     i_pushData,
  input  logic       i_pop,
  output if_id_t     o_head,
  output logic [1:0] o_count
);

  if_id_t     r_entry0;
  if_id_t     r_entry1;
  logic [1:0] r_count;
  logic       w_pop;
  logic       w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && (w_pop || (r_count != 2'd2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_entry0 <= '0;
      r_entry1 <= '0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_entry0 <= i_pushData;
          else                 r_entry1 <= i_pushData;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_entry0 <= r_entry1;
          r_count  <= r_count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the new word lands behind any survivor.
          if (r_count == 2'd1) begin
            r_entry0 <= i_pushData;
          end else begin
            r_entry0 <= r_entry1;
            r_entry1 <= i_pushData;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_entry0;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding request FSM, wrong-path drop flag
// and the 2-entry queue whose head forms the IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned      WIDTH    = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC = '0
)(
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [ILEN-1:0]  imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_pc,
  output logic [ILEN-1:0]  id_instr,
  input  logic             id_ready
);

  fetch_state_t     r_state;
  fetch_state_t     w_nextState;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_nextPc;
  logic [WIDTH-1:0] r_inflightPc;
  logic [WIDTH-1:0] r_lastPc;
  logic             r_drop;
  logic             w_nextDrop;
  logic             w_accept;
  logic             w_rspValid;
  logic             w_push;
  logic             w_pop;
  if_id_t           w_pushData;
  if_id_t           w_head;
  logic [1:0]       w_count;

  assign imem_req_valid = !rst && (r_state == FS_REQ) && (w_count < 2'd2);
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_rspValid     = (r_state == FS_WAIT) && imem_rsp_valid;
  assign w_pop          = id_valid && id_ready;

  assign w_pushData.pc    = XLEN'(r_inflightPc);
  assign w_pushData.instr = imem_rsp_data;

  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_nextDrop  = r_drop;
    w_push      = 1'b0;
    case (r_state)
      FS_REQ: begin
        if (w_accept) begin
          w_nextState = FS_WAIT;
          w_nextPc    = r_pc + WIDTH'(4);
        end
      end
      FS_WAIT: begin
        if (w_rspValid) begin
          w_nextState = FS_REQ;
          w_nextDrop  = 1'b0;
          w_push      = !r_drop;
        end
      end
      default: ;
    endcase
    // A redirect overrides everything: any word still in flight becomes wrong-path.
    if (redirect_valid) begin
      w_nextPc = redirect_pc & ~WIDTH'(3);
      w_push   = 1'b0;
      if (w_rspValid) begin
        w_nextState = FS_REQ;
        w_nextDrop  = 1'b0;
      end else if ((r_state == FS_WAIT) || w_accept) begin
        w_nextState = FS_WAIT;
        w_nextDrop  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FS_REQ;
      r_pc         <= RESET_PC;
      r_inflightPc <= '0;
      r_drop       <= 1'b0;
      r_lastPc     <= '0;
    end else begin
      r_state  <= w_nextState;
      r_pc     <= w_nextPc;
      r_drop   <= w_nextDrop;
      r_lastPc <= id_pc;
      if (w_accept) r_inflightPc <= r_pc;
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redirect_valid),
    .i_push     (w_push),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  // The payload pc is XLEN wide; resize to the stage's WIDTH at the boundary.
  assign id_valid = (w_count != 2'd0);
  assign id_pc    = id_valid ? WIDTH'(w_head.pc) : r_lastPc;
  assign id_instr = id_valid ? w_head.instr : NOP_INSTR;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic, with a
// transaction-level model (instruction queue + one outstanding fetch) compared every cycle.
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] XORKEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid, reqReady, rspValid, redirValid, idValid, idReady;
  logic [31:0] reqAddr, rspData, redirPc, idPc, idInstr;

  logic        rst1 = 1'b1;
  logic        reqValid1, reqReady1, rspValid1, redirValid1, idValid1, idReady1;
  logic [31:0] reqAddr1, rspData1, redirPc1, idPc1, idInstr1;

  always #5 clk = ~clk;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(reqValid), .imem_req_addr(reqAddr), .imem_req_ready(reqReady),
    .imem_rsp_valid(rspValid), .imem_rsp_data(rspData),
    .redirect_valid(redirValid), .redirect_pc(redirPc),
    .id_valid(idValid), .id_pc(idPc), .id_instr(idInstr), .id_ready(idReady)
  );

  fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst(rst1),
    .imem_req_valid(reqValid1), .imem_req_addr(reqAddr1), .imem_req_ready(reqReady1),
    .imem_rsp_valid(rspValid1), .imem_rsp_data(rspData1),
    .redirect_valid(redirValid1), .redirect_pc(redirPc1),
    .id_valid(idValid1), .id_pc(idPc1), .id_instr(idInstr1), .id_ready(idReady1)
  );

  int checks = 0;
  int errors = 0;

  bit          kRst, kReady, kIdReady, kRedir, kSpur;
  logic [31:0] kRedirPc;
  int          kDelay;

  bit          memBusy;
  int          memDelay;
  logic [31:0] memWord;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mQ[$];
  logic [31:0] mPc, mInflight, mLastPc;
  bit          mBusy, mDrop;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mPc       = 32'h0;
    mInflight = 32'h0;
    mLastPc   = 32'h0;
    mBusy     = 1'b0;
    mDrop     = 1'b0;
  endtask

  task automatic modelStep(input bit reqV, input bit idV, input logic [31:0] curPc);
    bit     accept;
    bit     rspUsed;
    entry_t e;
    accept  = reqV && reqReady;
    rspUsed = mBusy && rspValid;
    mLastPc = curPc;
    if (redirValid) begin
      mQ.delete();
      mPc = {redirPc[31:2], 2'b00};
      if (rspUsed) begin
        mBusy = 1'b0;
        mDrop = 1'b0;
      end else if (mBusy || accept) begin
        mBusy = 1'b1;
        mDrop = 1'b1;
      end
    end else begin
      if (idV && idReady) void'(mQ.pop_front());
      if (rspUsed) begin
        mBusy = 1'b0;
        if (mDrop) mDrop = 1'b0;
        else begin
          e.pc    = mInflight;
          e.instr = rspData;
          mQ.push_back(e);
        end
      end
      if (accept) begin
        mBusy     = 1'b1;
        mInflight = mPc;
        mPc       = mPc + 32'd4;
      end
    end
  endtask

  task automatic checkOutput();
    bit          expReq;
    bit          expIdV;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    if (rst) modelReset();
    expReq   = !rst && !mBusy && (mQ.size() < 2);
    expIdV   = (mQ.size() != 0);
    expPc    = expIdV ? mQ[0].pc : mLastPc;
    expInstr = expIdV ? mQ[0].instr : NOP;
    checkVal("req_valid", 32'(reqValid), 32'(expReq));
    if (expReq) checkVal("req_addr", reqAddr, mPc);
    checkVal("id_valid", 32'(idValid), 32'(expIdV));
    checkVal("id_pc", idPc, expPc);
    checkVal("id_instr", idInstr, expInstr);
    if (!rst) modelStep(expReq, expIdV, expPc);
  endtask

  // One clock cycle: drive knobs and the memory after the edge, check on the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    rst      = kRst;
    rspValid = 1'b0;
    rspData  = $urandom;
    if (kRst) memBusy = 1'b0;
    if (memBusy) begin
      if (memDelay == 0) begin
        rspValid = 1'b1;
        rspData  = memWord;
        memBusy  = 1'b0;
      end else begin
        memDelay--;
      end
    end else if (kSpur) begin
      rspValid = 1'b1;
    end
    reqReady   = kReady;
    idReady    = kIdReady;
    redirValid = kRedir;
    redirPc    = kRedirPc;
    @(negedge clk);
    checkOutput();
    if (reqValid && reqReady && !memBusy) begin
      memBusy  = 1'b1;
      memDelay = kDelay;
      memWord  = reqAddr ^ XORKEY;
    end
  endtask

  logic [31:0] popped[$];
  bit          found, gotReq, gotId;

  initial begin
    kRst = 1'b1; kReady = 1'b0; kIdReady = 1'b0; kRedir = 1'b0; kSpur = 1'b0;
    kRedirPc = 32'h0; kDelay = 0;
    memBusy = 1'b0; memDelay = 0; memWord = 32'h0;
    reqReady = 1'b0; rspValid = 1'b0; rspData = 32'h0; redirValid = 1'b0;
    redirPc = 32'h0; idReady = 1'b0;
    reqReady1 = 1'b0; rspValid1 = 1'b0; rspData1 = 32'h0; redirValid1 = 1'b0;
    redirPc1 = 32'h0; idReady1 = 1'b0;
    modelReset();

    repeat (2) applyStimulus();
    checkVal("reset_req_valid", 32'(reqValid), 32'd0);
    checkVal("reset_id_valid", 32'(idValid), 32'd0);
    checkVal("reset_id_instr", idInstr, NOP);
    checkVal("reset_id_pc", idPc, 32'h0);

    // Zero-wait stream with decode always ready.
    kRst = 1'b0; kReady = 1'b1; kIdReady = 1'b1; kDelay = 0;
    for (int c = 0; c < 7; c++) begin
      applyStimulus();
      if (c == 0) begin
        checkVal("t2_first_req_valid", 32'(reqValid), 32'd1);
        checkVal("t2_first_addr", reqAddr, 32'h0);
      end
      if (c >= 2 && (c % 2) == 0) begin
        checkVal("t2_id_valid", 32'(idValid), 32'd1);
        checkVal("t2_id_pc", idPc, 32'((c - 2) * 2));
        checkVal("t2_id_instr", idInstr, 32'((c - 2) * 2) ^ XORKEY);
      end
    end

    // Reset while a fetch is outstanding.
    kRst = 1'b1;
    applyStimulus();
    checkVal("t1_req_valid_in_reset", 32'(reqValid), 32'd0);
    checkVal("t1_id_valid_in_reset", 32'(idValid), 32'd0);
    checkVal("t1_id_instr_in_reset", idInstr, NOP);
    checkVal("t1_id_pc_in_reset", idPc, 32'h0);
    applyStimulus();

    // Release with a stale response in the same cycle, then back-pressure decode.
    kRst = 1'b0; kSpur = 1'b1; kIdReady = 1'b0;
    applyStimulus();
    checkVal("t1_req_after_reset", 32'(reqValid), 32'd1);
    checkVal("t1_addr_after_reset", reqAddr, 32'h0);
    kSpur = 1'b0;
    for (int c = 1; c < 10; c++) applyStimulus();
    checkVal("t3_req_held_off", 32'(reqValid), 32'd0);
    checkVal("t3_head_valid", 32'(idValid), 32'd1);
    checkVal("t3_head_pc", idPc, 32'h0);

    kIdReady = 1'b1;
    popped.delete();
    for (int c = 0; c < 8; c++) begin
      applyStimulus();
      if (idValid && idReady) popped.push_back(idPc);
    end
    checkVal("t3_pop_count_ge3", 32'(popped.size() >= 3), 32'd1);
    if (popped.size() >= 3) begin
      checkVal("t3_pop0", popped[0], 32'h0);
      checkVal("t3_pop1", popped[1], 32'h4);
      checkVal("t3_pop2", popped[2], 32'h8);
    end

    // Redirect while a slow fetch is in flight.
    kDelay = 2;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus();
      if (memBusy && memDelay > 0) found = 1'b1;
    end
    checkVal("t4_wait_reached", 32'(found), 32'd1);
    kRedir = 1'b1; kRedirPc = 32'h0000_0103;
    applyStimulus();
    kRedir = 1'b0;
    gotReq = 1'b0; gotId = 1'b0;
    for (int i = 0; i < 30 && !(gotReq && gotId); i++) begin
      applyStimulus();
      if (!gotReq && reqValid) begin
        gotReq = 1'b1;
        checkVal("t4_next_addr", reqAddr, 32'h0000_0100);
      end
      if (!gotId && idValid) begin
        gotId = 1'b1;
        checkVal("t4_first_id_pc", idPc, 32'h0000_0100);
      end
    end
    checkVal("t4_completed", 32'(gotReq && gotId), 32'd1);

    // Redirect coinciding with the response and a decode pop.
    kIdReady = 1'b0; kDelay = 1; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      applyStimulus();
      if (memBusy && memDelay == 0 && mQ.size() == 1) found = 1'b1;
    end
    checkVal("t5_setup_reached", 32'(found), 32'd1);
    kRedir = 1'b1; kRedirPc = 32'h0000_0200; kIdReady = 1'b1;
    applyStimulus();
    kRedir = 1'b0;
    applyStimulus();
    checkVal("t5_queue_empty", 32'(idValid), 32'd0);
    checkVal("t5_req_valid", 32'(reqValid), 32'd1);
    checkVal("t5_next_addr", reqAddr, 32'h0000_0200);

    // PC wrap on the second instance, with a spurious response while idle.
    @(posedge clk);
    #1;
    rst1 = 1'b0; reqReady1 = 1'b1; idReady1 = 1'b1;
    rspValid1 = 1'b1; rspData1 = 32'hDEAD_BEEF;
    @(negedge clk);
    checkVal("t6_req_valid", 32'(reqValid1), 32'd1);
    checkVal("t6_first_addr", reqAddr1, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    rspValid1 = 1'b1; rspData1 = 32'h1111_1111;
    @(negedge clk);
    checkVal("t6_wait_req_valid", 32'(reqValid1), 32'd0);
    @(posedge clk);
    #1;
    rspValid1 = 1'b0;
    @(negedge clk);
    checkVal("t6_id_valid", 32'(idValid1), 32'd1);
    checkVal("t6_id_pc", idPc1, 32'hFFFF_FFFC);
    checkVal("t6_id_instr", idInstr1, 32'h1111_1111);
    checkVal("t6_wrap_req_valid", 32'(reqValid1), 32'd1);
    checkVal("t6_wrap_addr", reqAddr1, 32'h0000_0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      kRst     = ($urandom_range(0, 399) == 0);
      kReady   = ($urandom_range(0, 3) != 0);
      kIdReady = ($urandom_range(0, 3) != 0);
      kRedir   = ($urandom_range(0, 11) == 0);
      kRedirPc = $urandom;
      kSpur    = ($urandom_range(0, 7) == 0);
      kDelay   = $urandom_range(0, 3);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
